// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt controller priority logic.
// Provides the resolver FSM state type and level-width/spurious helpers.
package pic_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } pr_state_t;

    // Width of a level index for n interrupt levels (at least one bit).
    function automatic int level_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Level reported for a spurious acknowledge: the lowest fixed level.
    function automatic int spurious_level(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rot_prio_encoder.sv
// Rotating priority encoder: finds the first set bit of vec, scanning from
// (lowest_pri+1) mod NUM_IRQ upward with wrap. Ports: vec, lowest_pri in; found, level out.
module rot_prio_encoder
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int LEVEL_W = level_w(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [LEVEL_W-1:0] lowest_pri,
    output logic               found,
    output logic [LEVEL_W-1:0] level
);

    logic [LEVEL_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        level = '0;
        idx   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            idx = LEVEL_W'((int'(lowest_pri) + 1 + i) % NUM_IRQ);
            if (!found && vec[idx]) begin
                found = 1'b1;
                level = idx;
            end
        end
    end

endmodule

// File: rtl/priority_resolver_rot.sv
// Rotating-priority resolver with in-service register, nesting, AEOI and EOI.
// Ports: clock/reset; irr, imr, mode bits, ack/eoi/set_prio commands in;
//        int_req, ack_valid, ack_level, ack_spurious, isr out.
module priority_resolver_rot
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int LEVEL_W = level_w(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               rotate_mode,
    input  logic               special_mask,
    input  logic               aeoi,
    input  logic               ack,
    input  logic               eoi,
    input  logic               eoi_specific,
    input  logic [LEVEL_W-1:0] eoi_level,
    input  logic               set_prio,
    input  logic [LEVEL_W-1:0] prio_level,
    output logic               int_req,
    output logic               ack_valid,
    output logic [LEVEL_W-1:0] ack_level,
    output logic               ack_spurious,
    output logic [NUM_IRQ-1:0] isr
);

    localparam logic [LEVEL_W-1:0] SPUR = LEVEL_W'(spurious_level(NUM_IRQ));
    localparam logic [NUM_IRQ-1:0] ONE  = NUM_IRQ'(1);

    pr_state_t          state;
    pr_state_t          state_n;
    logic [LEVEL_W-1:0] lowest_pri;
    logic [LEVEL_W-1:0] lowest_pri_n;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] ack_set;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic [NUM_IRQ-1:0] isr_n;
    logic               win_found;
    logic [LEVEL_W-1:0] win_lvl;
    logic               isr_found;
    logic [LEVEL_W-1:0] isr_hi;
    logic               qual;
    logic               grant;

    // Position in the rotated order; 0 is the highest priority.
    function automatic int rank(input logic [LEVEL_W-1:0] l,
                                input logic [LEVEL_W-1:0] lp);
        return (int'(l) + NUM_IRQ - int'(lp) - 1) % NUM_IRQ;
    endfunction

    assign cand = irr & ~imr;

    rot_prio_encoder #(
        .NUM_IRQ    (NUM_IRQ),
        .LEVEL_W    (LEVEL_W)
    ) u_win_enc (
        .vec        (cand),
        .lowest_pri (lowest_pri),
        .found      (win_found),
        .level      (win_lvl)
    );

    rot_prio_encoder #(
        .NUM_IRQ    (NUM_IRQ),
        .LEVEL_W    (LEVEL_W)
    ) u_isr_enc (
        .vec        (isr),
        .lowest_pri (lowest_pri),
        .found      (isr_found),
        .level      (isr_hi)
    );

    // Special mask: only the winner's own ISR bit blocks it (it is unmasked,
    // so isr & ~imr agrees with isr there). Otherwise any in-service level of
    // equal or higher priority blocks it.
    always_comb begin
        qual = 1'b0;
        if (win_found) begin
            if (special_mask) begin
                qual = !isr[win_lvl];
            end else begin
                qual = !isr_found ||
                       (rank(win_lvl, lowest_pri) < rank(isr_hi, lowest_pri));
            end
        end
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!ack && qual) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_n = IDLE;
                    grant   = qual;
                end else if (!qual) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack_set      = '0;
        eoi_clr      = '0;
        lowest_pri_n = lowest_pri;
        if (grant && !aeoi) begin
            ack_set = ONE << win_lvl;
        end
        if (eoi) begin
            if (eoi_specific) begin
                if (int'(eoi_level) < NUM_IRQ) begin
                    eoi_clr = ONE << eoi_level;
                end
            end else if (isr_found) begin
                eoi_clr = ONE << isr_hi;
                if (rotate_mode) begin
                    lowest_pri_n = isr_hi;
                end
            end
        end
        if (grant && aeoi && rotate_mode) begin
            lowest_pri_n = win_lvl;
        end
        // Explicit priority set wins over any rotation this cycle.
        if (set_prio && (int'(prio_level) < NUM_IRQ)) begin
            lowest_pri_n = prio_level;
        end
        isr_n = (isr & ~eoi_clr) | ack_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            int_req      <= 1'b0;
            ack_valid    <= 1'b0;
            ack_level    <= '0;
            ack_spurious <= 1'b0;
            isr          <= '0;
            lowest_pri   <= SPUR;
        end else begin
            state        <= state_n;
            int_req      <= (state_n == REQ);
            ack_valid    <= ack;
            ack_spurious <= ack && !grant;
            if (ack) begin
                ack_level <= grant ? win_lvl : SPUR;
            end
            isr          <= isr_n;
            lowest_pri   <= lowest_pri_n;
        end
    end

endmodule

// File: tb/tb_priority_resolver_rot.sv
// Self-checking bench for priority_resolver_rot (8-level model-checked
// instance plus a 16-level instance for wide-parameter directed checks).
module tb_priority_resolver_rot;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] irr, imr, isr8;
    logic       rotate_mode, special_mask, aeoi, ack, eoi, eoi_specific;
    logic [2:0] eoi_level, prio_level, ack_level8;
    logic       set_prio, int_req8, ack_valid8, ack_spur8;

    logic [15:0] irr16, imr16, isr16;
    logic        ack16, eoi16, eoi_spec16, set_prio16;
    logic [3:0]  eoi_lvl16, prio16, ack_level16;
    logic        int_req16, ack_valid16, ack_spur16;

    int checks   = 0;
    int failures = 0;

    priority_resolver_rot #(.NUM_IRQ(8)) dut8 (
        .clock        (clk),
        .reset        (reset),
        .irr          (irr),
        .imr          (imr),
        .rotate_mode  (rotate_mode),
        .special_mask (special_mask),
        .aeoi         (aeoi),
        .ack          (ack),
        .eoi          (eoi),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .set_prio     (set_prio),
        .prio_level   (prio_level),
        .int_req      (int_req8),
        .ack_valid    (ack_valid8),
        .ack_level    (ack_level8),
        .ack_spurious (ack_spur8),
        .isr          (isr8)
    );

    priority_resolver_rot #(.NUM_IRQ(16)) dut16 (
        .clock        (clk),
        .reset        (reset),
        .irr          (irr16),
        .imr          (imr16),
        .rotate_mode  (1'b0),
        .special_mask (1'b0),
        .aeoi         (1'b0),
        .ack          (ack16),
        .eoi          (eoi16),
        .eoi_specific (eoi_spec16),
        .eoi_level    (eoi_lvl16),
        .set_prio     (set_prio16),
        .prio_level   (prio16),
        .int_req      (int_req16),
        .ack_valid    (ack_valid16),
        .ack_level    (ack_level16),
        .ack_spurious (ack_spur16),
        .isr          (isr16)
    );

    // Reference state for the 8-level instance.
    logic [7:0] m_isr;
    int         m_lp, m_al;
    bit         m_pend, m_av, m_as;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [7:0] v, input int l);
        return 1'(v >> l);
    endfunction

    // Walk levels from highest to lowest priority.
    function automatic void m_winner(input logic [7:0] cand, input logic [7:0] s,
                                     input bit sm, input int lp,
                                     output bit f, output int lvl);
        f = 0;
        lvl = 0;
        for (int k = 0; k < 8; k++) begin
            int l = (lp + 1 + k) % 8;
            if (!sm && bit_at(s, l)) return;
            if (bit_at(cand, l)) begin
                f = sm ? !bit_at(s, l) : 1'b1;
                lvl = l;
                return;
            end
        end
    endfunction

    function automatic void m_top_isr(input logic [7:0] s, input int lp,
                                      output bit f, output int lvl);
        f = 0;
        lvl = 0;
        for (int k = 0; k < 8; k++) begin
            int l = (lp + 1 + k) % 8;
            if (bit_at(s, l)) begin
                f = 1;
                lvl = l;
                return;
            end
        end
    endfunction

    task automatic tick();
        bit f, hf, gr;
        int wl, hl, nlp;
        logic [7:0] setv, clrv;
        if (reset) begin
            m_isr = 0; m_lp = 7; m_pend = 0;
            m_av = 0; m_al = 0; m_as = 0;
        end else begin
            m_winner(irr & ~imr, m_isr, special_mask, m_lp, f, wl);
            gr   = ack && m_pend && f;
            setv = (gr && !aeoi) ? 8'(1 << wl) : 8'h00;
            clrv = 8'h00;
            nlp  = m_lp;
            if (eoi) begin
                if (eoi_specific) begin
                    clrv = 8'(1 << eoi_level);
                end else begin
                    m_top_isr(m_isr, m_lp, hf, hl);
                    if (hf) begin
                        clrv = 8'(1 << hl);
                        if (rotate_mode) nlp = hl;
                    end
                end
            end
            if (gr && aeoi && rotate_mode) nlp = wl;
            if (set_prio) nlp = int'(prio_level);
            m_av = ack;
            m_as = ack && !gr;
            if (ack) m_al = gr ? wl : 7;
            m_pend = !ack && f;
            m_isr  = (m_isr & ~clrv) | setv;
            m_lp   = nlp;
        end
        @(posedge clk);
        #1;
        check("int_req", 32'(int_req8), 32'(m_pend));
        check("ack_valid", 32'(ack_valid8), 32'(m_av));
        check("ack_level", 32'(ack_level8), 32'(m_al));
        check("ack_spurious", 32'(ack_spur8), 32'(m_as));
        check("isr", 32'(isr8), 32'(m_isr));
    endtask

    task automatic pulse_ack();
        ack = 1;
        tick();
        ack = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1;
        irr = 0; imr = 0; rotate_mode = 0; special_mask = 0; aeoi = 0;
        ack = 0; eoi = 0; eoi_specific = 0; eoi_level = 0;
        set_prio = 0; prio_level = 0;
        irr16 = 0; imr16 = 0; ack16 = 0; eoi16 = 0; eoi_spec16 = 0;
        eoi_lvl16 = 0; set_prio16 = 0; prio16 = 0;
        tick();
        check("rst_int_req16", 32'(int_req16), 0);
        check("rst_isr16", 32'(isr16), 0);
        reset = 0;

        // 16 levels: rotate so 15 is highest, then ack with same-cycle EOI(15).
        set_prio16 = 1; prio16 = 4'd14;
        tick();
        set_prio16 = 0; irr16 = 16'h8001;
        tick();
        check("w16_int_req", 32'(int_req16), 1);
        ack16 = 1; eoi16 = 1; eoi_spec16 = 1; eoi_lvl16 = 4'd15;
        tick();
        ack16 = 0; eoi16 = 0; eoi_spec16 = 0;
        check("w16_ack_valid", 32'(ack_valid16), 1);
        check("w16_ack_level", 32'(ack_level16), 15);
        check("w16_isr", 32'(isr16), 32'h8000);
        check("w16_int_req_drop", 32'(int_req16), 0);
        eoi16 = 1; eoi_spec16 = 1;
        tick();
        eoi16 = 0; eoi_spec16 = 0; irr16 = 0;
        check("w16_eoi_spec", 32'(isr16), 0);

        // Basic request and acknowledge.
        irr = 8'h28;
        tick();
        check("t1_int_req", 32'(int_req8), 1);
        pulse_ack();
        check("t1_ack_level", 32'(ack_level8), 3);
        check("t1_isr", 32'(isr8), 8'h08);
        check("t1_int_req_drop", 32'(int_req8), 0);

        // Nesting: higher level passes, lower level is held off.
        irr = 8'h05;
        tick();
        check("t2_nest_hi", 32'(int_req8), 1);
        irr = 8'h10;
        tick();
        tick();
        check("t2_nest_lo", 32'(int_req8), 0);

        // Non-specific EOI with rotation.
        irr = 0; rotate_mode = 1; eoi = 1; eoi_specific = 0;
        tick();
        eoi = 0;
        check("t3_isr_clr", 32'(isr8), 0);
        irr = 8'h11;
        tick();
        check("t3_int_req", 32'(int_req8), 1);
        pulse_ack();
        check("t3_ack_level", 32'(ack_level8), 4);
        irr = 0; eoi = 1;
        tick();
        eoi = 0;

        // Request withdrawn as the ack arrives.
        irr = 8'h02;
        tick();
        check("t4_int_req", 32'(int_req8), 1);
        irr = 0;
        pulse_ack();
        check("t4_ack_valid", 32'(ack_valid8), 1);
        check("t4_spurious", 32'(ack_spur8), 1);
        check("t4_ack_level", 32'(ack_level8), 7);
        check("t4_isr", 32'(isr8), 0);

        // Special mask mode.
        rotate_mode = 0; reset = 1;
        tick();
        reset = 0; irr = 8'h04;
        tick();
        pulse_ack();
        check("t5_isr_pre", 32'(isr8), 8'h04);
        imr = 8'h04; special_mask = 1; irr = 8'h80;
        tick();
        check("t5_int_req", 32'(int_req8), 1);
        pulse_ack();
        check("t5_ack_level", 32'(ack_level8), 7);

        // Randomised operation against the reference model.
        for (int seg = 0; seg < 8; seg++) begin
            reset = 1;
            tick();
            reset = 0;
            rotate_mode  = 1'($urandom);
            special_mask = 1'($urandom);
            aeoi         = 1'($urandom);
            imr = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 3) == 0) irr = 8'($urandom & $urandom);
                ack          = ($urandom_range(0, 3) == 0);
                eoi          = ($urandom_range(0, 4) == 0);
                eoi_specific = 1'($urandom);
                eoi_level    = 3'($urandom);
                set_prio     = ($urandom_range(0, 19) == 0);
                prio_level   = 3'($urandom);
                reset        = ($urandom_range(0, 149) == 0);
                tick();
            end
            ack = 0; eoi = 0; set_prio = 0; reset = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
